vga_timing: RTL and testbench
=============================

# vga_timing

Video timing generator for the Cyclone V video controller, one stage downstream of the board top level. It runs on the pixel clock selected at the top level and produces HSYNC/VSYNC, a blanking flag, the active pixel coordinates and frame/line start strobes for the pixel pipeline and the video DAC. An optional colour-bar generator lets the output path be brought up without a frame buffer.

## Interface
- HDISP, 640: active pixels per line
- HFP, 16: horizontal front porch, in pixels
- HPULSE, 96: HSYNC pulse width, in pixels
- HBP, 48: horizontal back porch, in pixels
- VDISP, 480: active lines per frame
- VFP, 10: vertical front porch, in lines
- VPULSE, 2: VSYNC pulse width, in lines
- VBP, 33: vertical back porch, in lines
- CW, 11: width of counters and coordinates; must satisfy 2^CW > HDISP+HFP+HPULSE+HBP and 2^CW > VDISP+VFP+VPULSE+VBP
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  count enable; when low, all state and outputs hold
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- blank  out  1  high outside the active area
- x  out  CW  active column, 0..HDISP-1; holds 0 while blanked
- y  out  CW  active line, 0..VDISP-1; holds 0 while blanked
- sol  out  1  one-cycle pulse at pixel (0,y) of each active line
- sof  out  1  one-cycle pulse at pixel (0,0) of each frame
- rgb  out  24  test-pattern pixel {R,G,B}; see Configuration

## Operation
- Internal counters: hc counts 0..HTOTAL-1 where HTOTAL=HDISP+HFP+HPULSE+HBP; vc counts 0..VTOTAL-1 where VTOTAL=VDISP+VFP+VPULSE+VBP.
- Counters advance only on edges where en=1.
- hc wraps from HTOTAL-1 to 0. vc increments only on the hc wrap and wraps from VTOTAL-1 to 0 on the same edge as the hc wrap.
- Horizontal regions, by hc: active [0,HDISP); front porch; sync [HDISP+HFP, HDISP+HFP+HPULSE); back porch. The vertical regions use the same ordering on vc.
- hs=0 while hc is in the horizontal sync region. vs=0 while vc is in the vertical sync region; vs transitions aligned with the hc=0 boundary.
- blank=0 only when hc<HDISP and vc<VDISP.
- x=hc and y=vc while active; both 0 while blanked.
- sol=1 when hc=0 and vc<VDISP. sof=1 when hc=0 and vc=0.
- All outputs are registered decodes of the counters. No combinational path exists from any input to any output.
- Arithmetic is unsigned CW-bit. Region bounds are computed from the parameters at elaboration.

## Timing
- Reset values: hc=0, vc=0, hs=1, vs=1, blank=1, x=0, y=0, sol=0, sof=0, rgb=0.
- Latency: outputs on cycle t reflect the counter value present at cycle t-1.
  - First clock edge with en=1 after reset release: hc goes 0→1 and the outputs take the decode of (0,0), i.e. sof=1, sol=1, blank=0.
- en=0: counters and every output, including strobes, hold their value. A strobe that was high stays high while stalled; downstream qualifies strobes with en.
- Reset asserted mid-frame: immediate return to reset values. The next frame starts cleanly at (0,0) with no partial sync pulse.
- Frame period: HTOTAL×VTOTAL enabled cycles, i.e. 420000 with the defaults.

## Configuration
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - rgb drives 8 vertical colour bars, each HDISP/8 pixels wide, left to right: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - The bar index comes from a registered sub-counter that resets at each sol; HDISP/8 is truncated.
  - rgb=0 whenever blank=1. rgb has the same latency as x.
- Not defined: rgb is tied to 24'h0 and no pattern logic is synthesized.

## Test plan
- Defaults, en=1 for 2 frames: hs low for exactly 96 cycles per 800-cycle line, starting 656 cycles after sol; vs low for 2 lines (1600 cycles) per 525 lines; sof period 420000.
- Small parameters (HDISP=8, HFP=2, HPULSE=2, HBP=2, VDISP=4, VFP=1, VPULSE=1, VBP=1): x sequence 0..7 then 0 for 6 cycles; blank=1 on lines 4–6; y=3 on the last active line.
- en toggling 1,0,0,1 pseudo-randomly: counter and output trace equals the en=1 trace with stalled cycles removed; hs/vs/x/y constant during stalls.
- rst pulsed at (hc=300, vc=200): all outputs return to reset values asynchronously, before the next edge; first enabled edge after release gives sof=1, x=0, y=0.
- VGA_TEST_PATTERN_EN defined, defaults: rgb=FFFFFF for x=0..79, FFFF00 at x=80, 000000 at x=639, and 0 at hc=640..799.
- VGA_TEST_PATTERN_EN undefined: rgb=0 on every cycle of a full frame.

Source files
------------

// File: rtl/vga_timing.sv
// vga_timing: VGA video timing generator with an optional colour-bar source.
//
// Two counters walk the frame. hc runs over 0..HTOTAL-1 and vc over
// 0..VTOTAL-1, and both advance only on enabled edges. Every output is a
// registered decode of the counters, so the outputs on cycle t describe the
// counter value present on cycle t-1.
//
// Ports:
//   clk    in   pixel clock
//   rst    in   asynchronous reset, active-high
//   en     in   count enable; when low, all state and outputs hold
//   hs     out  horizontal sync, active-low
//   vs     out  vertical sync, active-low
//   blank  out  high outside the active area
//   x, y   out  active pixel coordinates; both are 0 while blanked
//   sol    out  strobe at pixel (0,y) of each active line
//   sof    out  strobe at pixel (0,0) of each frame
//   rgb    out  test-pattern pixel {R,G,B}
//
// Build option VGA_TEST_PATTERN_EN: when defined, rgb drives 8 vertical
// colour bars. When undefined, rgb is tied to 0 and no pattern logic exists.
module vga_timing #(
  parameter int HDISP  = 640,
  parameter int HFP    = 16,
  parameter int HPULSE = 96,
  parameter int HBP    = 48,
  parameter int VDISP  = 480,
  parameter int VFP    = 10,
  parameter int VPULSE = 2,
  parameter int VBP    = 33,
  parameter int CW     = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          sol,
  output logic          sof,
  output logic [23:0]   rgb
);

  // Region bounds, computed at elaboration time.
  localparam logic [CW-1:0] H_ACT = CW'(HDISP);
  localparam logic [CW-1:0] H_SS  = CW'(HDISP + HFP);
  localparam logic [CW-1:0] H_SE  = CW'(HDISP + HFP + HPULSE);
  localparam logic [CW-1:0] H_MAX = CW'(HDISP + HFP + HPULSE + HBP - 1);
  localparam logic [CW-1:0] V_ACT = CW'(VDISP);
  localparam logic [CW-1:0] V_SS  = CW'(VDISP + VFP);
  localparam logic [CW-1:0] V_SE  = CW'(VDISP + VFP + VPULSE);
  localparam logic [CW-1:0] V_MAX = CW'(VDISP + VFP + VPULSE + VBP - 1);

  logic [CW-1:0] hc, vc;
  logic          h_wrap, v_wrap, h_act, v_act, act;

  assign h_wrap = (hc == H_MAX);
  assign v_wrap = (vc == V_MAX);
  assign h_act  = (hc < H_ACT);
  assign v_act  = (vc < V_ACT);
  assign act    = h_act && v_act;

  // vc steps on the same edge that wraps hc. Because vs is decoded from vc,
  // its transitions therefore fall on the hc=0 boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (en) begin
      hc <= h_wrap ? '0 : hc + 1'b1;
      if (h_wrap) vc <= v_wrap ? '0 : vc + 1'b1;
    end
  end

  // Output register. The decode is taken from the current counter values,
  // which gives the one-cycle latency. Strobes are not cleared on stalls:
  // they hold along with everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs    <= 1'b1;
      vs    <= 1'b1;
      blank <= 1'b1;
      x     <= '0;
      y     <= '0;
      sol   <= 1'b0;
      sof   <= 1'b0;
    end else if (en) begin
      hs    <= !(hc >= H_SS && hc < H_SE);
      vs    <= !(vc >= V_SS && vc < V_SE);
      blank <= !act;
      x     <= act ? hc : '0;
      y     <= act ? vc : '0;
      sol   <= (hc == '0) && v_act;
      sof   <= (hc == '0) && (vc == '0);
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  // Bar width is HDISP/8, truncated. Any pixels left over at the right edge
  // keep the last index (black). The floor of 1 keeps tiny modes legal.
  localparam int            BW     = (HDISP / 8 > 0) ? HDISP / 8 : 1;
  localparam logic [CW-1:0] BW_MAX = CW'(BW - 1);

  logic [CW-1:0] sub;
  logic [2:0]    bar;

  function automatic logic [23:0] bar_colour(input logic [2:0] b);
    case (b)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // sub and bar follow hc. They clear on the hc wrap, so they restart at the
  // start of every line (the sol position), and the rgb register samples them
  // alongside x. This gives rgb the same latency as x.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub <= '0;
      bar <= '0;
      rgb <= '0;
    end else if (en) begin
      if (h_wrap) begin
        sub <= '0;
        bar <= '0;
      end else if (sub == BW_MAX) begin
        sub <= '0;
        if (bar != 3'd7) bar <= bar + 1'b1;
      end else begin
        sub <= sub + 1'b1;
      end
      rgb <= act ? bar_colour(bar) : 24'h0;
    end
  end
`else
  assign rgb = 24'h0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing. It drives two instances:
//   dut_d uses the default 640x480 timing and covers line timing, colour
//         bars and a mid-frame reset.
//   dut_s uses a tiny 14x7 mode and covers whole frames plus random stalls,
//         compared cycle by cycle against a reference model.
module tb_vga_timing;

  logic        clk = 1'b0;
  logic        rst_d = 1'b0, en_d = 1'b0;
  logic        rst_s = 1'b0, en_s = 1'b0;
  logic        hs_d, vs_d, blank_d, sol_d, sof_d;
  logic [10:0] x_d, y_d;
  logic [23:0] rgb_d;
  logic        hs_s, vs_s, blank_s, sol_s, sof_s;
  logic [10:0] x_s, y_s;
  logic [23:0] rgb_s;

  int nvec = 0;
  int nerr = 0;

  typedef struct packed {
    logic        hs, vs, blank;
    logic [10:0] x, y;
    logic        sol, sof;
    logic [23:0] rgb;
  } obs_t;

  localparam obs_t RST_VAL = '{hs: 1'b1, vs: 1'b1, blank: 1'b1, x: 11'd0,
                               y: 11'd0, sol: 1'b0, sof: 1'b0, rgb: 24'h0};

  always #5 clk = ~clk;

  vga_timing dut_d (
    .clk(clk), .rst(rst_d), .en(en_d), .hs(hs_d), .vs(vs_d), .blank(blank_d),
    .x(x_d), .y(y_d), .sol(sol_d), .sof(sof_d), .rgb(rgb_d)
  );

  vga_timing #(
    .HDISP(8), .HFP(2), .HPULSE(2), .HBP(2),
    .VDISP(4), .VFP(1), .VPULSE(1), .VBP(1), .CW(11)
  ) dut_s (
    .clk(clk), .rst(rst_s), .en(en_s), .hs(hs_s), .vs(vs_s), .blank(blank_s),
    .x(x_s), .y(y_s), .sol(sol_s), .sof(sof_s), .rgb(rgb_s)
  );

  function automatic logic [23:0] bar_rgb(input int i);
    case (i)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected outputs of the 14x7 instance after k enabled edges since reset.
  // HTOTAL is 14 and VTOTAL is 7. hsync covers h 10..11, vsync covers line 5,
  // and the bar width is 1 pixel.
  function automatic obs_t model_s(input int k);
    obs_t e;
    int c, h, v;
    e = RST_VAL;
    if (k > 0) begin
      c = k - 1;
      h = c % 14;
      v = (c / 14) % 7;
      e.hs    = !(h >= 10 && h < 12);
      e.vs    = !(v == 5);
      e.blank = !(h < 8 && v < 4);
      e.x     = e.blank ? 11'd0 : 11'(h);
      e.y     = e.blank ? 11'd0 : 11'(v);
      e.sol   = (h == 0) && (v < 4);
      e.sof   = (h == 0) && (v == 0);
`ifdef VGA_TEST_PATTERN_EN
      e.rgb   = e.blank ? 24'h0 : bar_rgb(h);
`endif
    end
    return e;
  endfunction

  task automatic test_reset();
    obs_t g;
    g = '{hs_d, vs_d, blank_d, x_d, y_d, sol_d, sof_d, rgb_d};
    nvec++;
    if (g !== RST_VAL) begin
      nerr++;
      $display("FAIL reset_d got %h expected %h", g, RST_VAL);
    end
    g = '{hs_s, vs_s, blank_s, x_s, y_s, sol_s, sof_s, rgb_s};
    nvec++;
    if (g !== RST_VAL) begin
      nerr++;
      $display("FAIL reset_s got %h expected %h", g, RST_VAL);
    end
  endtask

  // Default mode: one full 800-cycle line and then the first cycle of line 1.
  // Index t is the output cycle, and t=0 is the first enabled edge after reset.
  task automatic test_line();
    obs_t g, e;
    int h, ln, nlow, first_low;
    nlow = 0;
    first_low = -1;
    @(negedge clk);
    rst_d = 1'b0;
    en_d  = 1'b1;
    for (int t = 0; t <= 800; t++) begin
      @(negedge clk);
      h  = (t < 800) ? t : 0;
      ln = (t < 800) ? 0 : 1;
      e = RST_VAL;
      e.hs    = !(h >= 656 && h < 752);
      e.vs    = 1'b1;
      e.blank = !(h < 640);
      e.x     = e.blank ? 11'd0 : 11'(h);
      e.y     = e.blank ? 11'd0 : 11'(ln);
      e.sol   = (h == 0);
      e.sof   = (t == 0);
`ifdef VGA_TEST_PATTERN_EN
      e.rgb   = e.blank ? 24'h0 : bar_rgb(h / 80);
`endif
      g = '{hs_d, vs_d, blank_d, x_d, y_d, sol_d, sof_d, rgb_d};
      nvec++;
      if (g !== e) begin
        nerr++;
        $display("FAIL line_d t=%0d got %h expected %h", t, g, e);
      end
      if (t < 800 && hs_d === 1'b0) begin
        nlow++;
        if (first_low < 0) first_low = t;
      end
    end
    nvec++;
    if (nlow != 96) begin
      nerr++;
      $display("FAIL hs_width got %0d expected 96", nlow);
    end
    nvec++;
    if (first_low != 656) begin
      nerr++;
      $display("FAIL hs_start got %0d expected 656", first_low);
    end
  endtask

  // Runs on from test_line: 801 edges so far, so the counters sit at (1,1).
  // The 299 extra edges leave the outputs showing (299,1) when reset hits.
  task automatic test_async_reset();
    obs_t g, e;
    for (int i = 0; i < 299; i++) @(negedge clk);
    nvec++;
    if (x_d !== 11'd299 || y_d !== 11'd1) begin
      nerr++;
      $display("FAIL pre_rst got x=%0d y=%0d expected x=299 y=1", x_d, y_d);
    end
    rst_d = 1'b1;
    #1;
    g = '{hs_d, vs_d, blank_d, x_d, y_d, sol_d, sof_d, rgb_d};
    nvec++;
    if (g !== RST_VAL) begin
      nerr++;
      $display("FAIL async_rst got %h expected %h", g, RST_VAL);
    end
    @(negedge clk);
    g = '{hs_d, vs_d, blank_d, x_d, y_d, sol_d, sof_d, rgb_d};
    nvec++;
    if (g !== RST_VAL) begin
      nerr++;
      $display("FAIL rst_held got %h expected %h", g, RST_VAL);
    end
    rst_d = 1'b0;
    @(negedge clk);
    e = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, x: 11'd0, y: 11'd0, sol: 1'b1,
          sof: 1'b1, rgb: 24'h0};
`ifdef VGA_TEST_PATTERN_EN
    e.rgb = 24'hFFFFFF;
`endif
    g = '{hs_d, vs_d, blank_d, x_d, y_d, sol_d, sof_d, rgb_d};
    nvec++;
    if (g !== e) begin
      nerr++;
      $display("FAIL post_rst got %h expected %h", g, e);
    end
  endtask

  // Small mode: two full frames (2 x 98 cycles) with en held high.
  task automatic test_small_frame();
    obs_t g, e;
    int nsof;
    nsof = 0;
    @(negedge clk);
    rst_s = 1'b0;
    en_s  = 1'b1;
    for (int k = 1; k <= 196; k++) begin
      @(negedge clk);
      e = model_s(k);
      g = '{hs_s, vs_s, blank_s, x_s, y_s, sol_s, sof_s, rgb_s};
      nvec++;
      if (g !== e) begin
        nerr++;
        $display("FAIL small k=%0d got %h expected %h", k, g, e);
      end
      if (sof_s === 1'b1) nsof++;
      // Last active line, pixel 7.
      if (k == 50) begin
        nvec++;
        if (y_s !== 11'd3 || x_s !== 11'd7) begin
          nerr++;
          $display("FAIL last_line got x=%0d y=%0d expected x=7 y=3", x_s, y_s);
        end
      end
      // Second frame start, 98 cycles after the first.
      if (k == 99) begin
        nvec++;
        if (sof_s !== 1'b1) begin
          nerr++;
          $display("FAIL sof_period got %b expected 1", sof_s);
        end
      end
    end
    nvec++;
    if (nsof != 2) begin
      nerr++;
      $display("FAIL sof_count got %0d expected 2", nsof);
    end
  endtask

  // Random stalls: after every cycle the outputs must match the model at the
  // number of enabled edges seen so far, and hold during stalls.
  task automatic test_stall();
    obs_t g, e;
    int k;
    k = 0;
    @(negedge clk);
    rst_s = 1'b1;
    en_s  = 1'b0;
    #1;
    rst_s = 1'b0;
    for (int n = 0; n < 300; n++) begin
      en_s = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (en_s) k++;
      e = model_s(k);
      g = '{hs_s, vs_s, blank_s, x_s, y_s, sol_s, sof_s, rgb_s};
      nvec++;
      if (g !== e) begin
        nerr++;
        $display("FAIL stall n=%0d k=%0d got %h expected %h", n, k, g, e);
      end
    end
    en_s = 1'b0;
  endtask

  initial begin
    #1;
    rst_d = 1'b1;
    rst_s = 1'b1;
    #1;
    test_reset();
    test_line();
    test_async_reset();
    test_small_frame();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
